truth_table_sweeper: RTL and testbench

- Sequencer that drives an N-input combinational function block through every input vector in ascending order, as an automated exhaustive sweep.
- Samples the block's single output after a programmable settle time and assembles the captured truth table.
- Compares the captured table against an expected table and reports pass/fail plus the first failing index.
- Sits beside the combinational unit under check; the unit's inputs come from abc and its output returns on z.

---
 rtl/truth_table_sweeper.sv | 125 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Purpose : exhaustive truth-table sweep of an N_IN-input combinational block,
//           capturing its output per vector and checking it against an expected table.
// Latency : 2**N_IN*(SETTLE+1) cycles from the start edge to the done pulse.
// Backpressure: none; start is taken only when idle, abort ends a sweep at the next edge.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      begin a sweep (only when idle) / cancel a running sweep
//   exp_tbl           expected table, bit i = z for abc==i, latched on the start edge
//   abc, z            vector driven to the block under check / its single output
//   busy, done        sweep in progress / one-cycle completion pulse
//   tbl               captured table
//   pass              captured table equals the latched expected table
//   err_valid         at least one mismatch
//   first_err         lowest mismatching index (0 if none)
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_tbl,
  output logic [N_IN-1:0]      abc,
  input  logic                 z,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tbl,
  output logic                 pass,
  output logic                 err_valid,
  output logic [N_IN-1:0]      first_err
);

  localparam int W  = 2**N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    exp_q;

  // Table as it will look once the current sample lands; used for the final
  // compare so the last vector is included on the completing edge.
  logic [W-1:0]    tbl_fin;
  logic [W-1:0]    diff;
  logic [N_IN-1:0] first_c;

  always_comb begin
    tbl_fin      = tbl;
    tbl_fin[idx] = z;
    diff         = tbl_fin ^ exp_q;
    first_c      = '0;
    // Scan downward so the lowest mismatching index is the one left standing.
    for (int i = W - 1; i >= 0; i--) begin
      if (diff[i]) first_c = i[N_IN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      abc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tbl       <= '0;
      pass      <= 1'b0;
      err_valid <= 1'b0;
      first_err <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          abc <= '0;
          if (start) begin
            state     <= RUN;
            idx       <= '0;
            cnt       <= '0;
            tbl       <= '0;
            pass      <= 1'b0;
            err_valid <= 1'b0;
            first_err <= '0;
            exp_q     <= exp_tbl;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial capture in tbl is kept; no verdict is produced.
            state <= IDLE;
            busy  <= 1'b0;
            abc   <= '0;
            pass  <= 1'b0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            tbl <= tbl_fin;
            cnt <= '0;
            if (idx != IDX_LAST) begin
              idx <= idx + 1'b1;
              abc <= idx + 1'b1;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              abc       <= '0;
              pass      <= (diff == '0);
              err_valid <= |diff;
              first_err <= first_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Exercises three sweepers (SETTLE = 0, 1, 2) sharing control inputs, each
// driving its own model of the combinational block.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] exp_tbl;

  logic [2:0] abc_a [3];
  logic       z_a   [3];
  logic       busy_a[3];
  logic       done_a[3];
  logic [7:0] tbl_a [3];
  logic       pass_a[3];
  logic       ev_a  [3];
  logic [2:0] fe_a  [3];

  int         mode;     // 0 majority, 1 odd parity, 2 stuck at 0, 3 random table
  logic       dly;      // block output delayed by two registers
  logic [7:0] rnd_tbl;
  int         checks;
  int         passed;

  // Behavioural function of the block under check.
  function automatic logic fz(input int m, input logic [7:0] rt, input int v);
    int ones;
    ones = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
    case (m)
      0:       return ones >= 2;
      1:       return (ones % 2) == 1;
      2:       return 1'b0;
      default: return rt[v];
    endcase
  endfunction

  // Table a sweeper with settle s should capture when the block lags by d
  // registers: vector k is sampled at edge (k+1)(s+1) and sees the block's
  // response to whatever abc held d+1 edges earlier (0 before the sweep).
  function automatic logic [7:0] ref_tbl(input int s, input int d);
    logic [7:0] r;
    int e, src, v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      e    = (k + 1) * (s + 1);
      src  = e - 1 - d;
      v    = (src < 0) ? 0 : src / (s + 1);
      r[k] = fz(mode, rnd_tbl, v);
    end
    return r;
  endfunction

  function automatic int lowest(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic p1, p2;
    always_ff @(posedge clk) begin
      p1 <= fz(mode, rnd_tbl, int'(abc_a[g]));
      p2 <= p1;
    end
    assign z_a[g] = dly ? p2 : fz(mode, rnd_tbl, int'(abc_a[g]));

    truth_table_sweeper #(.N_IN(3), .SETTLE(g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .exp_tbl   (exp_tbl),
      .abc       (abc_a[g]),
      .z         (z_a[g]),
      .busy      (busy_a[g]),
      .done      (done_a[g]),
      .tbl       (tbl_a[g]),
      .pass      (pass_a[g]),
      .err_valid (ev_a[g]),
      .first_err (fe_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_all_idle();
    for (int i = 0; i < 200 && (busy_a[0] | busy_a[1] | busy_a[2]); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Launches one sweep on instance sel and follows it to done. Reports the
  // cycle done was seen (-1 on timeout) and how many cycles had abc/busy off
  // the expected staircase. exp_tbl is scrambled after the start edge.
  task automatic do_sweep(input int sel, input int poke, output int done_cyc, output int abc_bad);
    wait_all_idle();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_tbl = 8'($urandom);
    done_cyc = -1;
    abc_bad  = 0;
    for (int t = 1; t <= 100; t++) begin
      if (t == poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done_a[sel]) begin
        done_cyc = t;
        break;
      end
      if (abc_a[sel] !== 3'(t / (sel + 1)) || busy_a[sel] !== 1'b1) abc_bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tbl = 8'h00;
    mode = 0; dly = 1'b0; rnd_tbl = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({abc_a[g], busy_a[g], done_a[g], tbl_a[g], pass_a[g], ev_a[g], fe_a[g]} !== 18'd0)
        $display("FAIL reset_outputs inst%0d got abc=%0d busy=%b done=%b tbl=%h pass=%b ev=%b fe=%0d want all 0",
                 g, abc_a[g], busy_a[g], done_a[g], tbl_a[g], pass_a[g], ev_a[g], fe_a[g]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_majority();
    int dc, ab;
    logic [7:0] r;
    mode = 0; dly = 1'b0; exp_tbl = 8'hE8;
    r = ref_tbl(1, 0);
    do_sweep(1, 0, dc, ab);
    checks++; if (dc !== 16) $display("FAIL maj_done_cycle got %0d want 16", dc); else passed++;
    checks++; if (ab !== 0) $display("FAIL maj_abc_steps got %0d bad cycles want 0", ab); else passed++;
    checks++; if (tbl_a[1] !== r) $display("FAIL maj_tbl got %h want %h", tbl_a[1], r); else passed++;
    checks++; if (pass_a[1] !== (r == 8'hE8)) $display("FAIL maj_pass got %b want %b", pass_a[1], r == 8'hE8); else passed++;
    checks++; if (ev_a[1] !== 1'b0) $display("FAIL maj_err_valid got %b want 0", ev_a[1]); else passed++;
    checks++; if ({abc_a[1], busy_a[1]} !== 4'd0) $display("FAIL maj_idle_after got abc=%0d busy=%b want 0/0", abc_a[1], busy_a[1]); else passed++;
    @(posedge clk); #1;
    checks++; if (done_a[1] !== 1'b0) $display("FAIL maj_done_pulse got %b want 0 one cycle later", done_a[1]); else passed++;
    checks++; if (tbl_a[1] !== r || pass_a[1] !== 1'b1) $display("FAIL maj_hold got tbl=%h pass=%b want %h/1", tbl_a[1], pass_a[1], r); else passed++;
  endtask

  task automatic test_parity();
    int dc, ab;
    logic [7:0] r;
    mode = 1; dly = 1'b0; exp_tbl = 8'h96;
    r = ref_tbl(0, 0);
    do_sweep(0, 0, dc, ab);
    checks++; if (dc !== 8) $display("FAIL par_done_cycle got %0d want 8", dc); else passed++;
    checks++; if (ab !== 0) $display("FAIL par_abc_steps got %0d bad cycles want 0", ab); else passed++;
    checks++; if (tbl_a[0] !== r) $display("FAIL par_tbl got %h want %h", tbl_a[0], r); else passed++;
    checks++; if (pass_a[0] !== 1'b1) $display("FAIL par_pass got %b want 1", pass_a[0]); else passed++;
  endtask

  task automatic test_stuck();
    int dc, ab;
    logic [7:0] r;
    mode = 2; dly = 1'b0; exp_tbl = 8'hE8;
    r = ref_tbl(1, 0);
    do_sweep(1, 0, dc, ab);
    checks++; if (tbl_a[1] !== r) $display("FAIL stuck_tbl got %h want %h", tbl_a[1], r); else passed++;
    checks++; if (pass_a[1] !== 1'b0) $display("FAIL stuck_pass got %b want 0", pass_a[1]); else passed++;
    checks++; if (ev_a[1] !== 1'b1) $display("FAIL stuck_err_valid got %b want 1", ev_a[1]); else passed++;
    checks++; if (fe_a[1] !== 3'(lowest(r ^ 8'hE8))) $display("FAIL stuck_first_err got %0d want %0d", fe_a[1], lowest(r ^ 8'hE8)); else passed++;
  endtask

  task automatic test_delayed();
    int dc, ab;
    logic [7:0] r;
    mode = 0; dly = 1'b1; exp_tbl = 8'hE8;
    r = ref_tbl(2, 2);
    do_sweep(2, 0, dc, ab);
    checks++; if (dc !== 24) $display("FAIL dly_s2_done_cycle got %0d want 24", dc); else passed++;
    checks++; if (tbl_a[2] !== r || pass_a[2] !== (r == 8'hE8)) $display("FAIL dly_s2_result got tbl=%h pass=%b want %h/%b", tbl_a[2], pass_a[2], r, r == 8'hE8); else passed++;
    exp_tbl = 8'hE8;
    r = ref_tbl(0, 2);
    do_sweep(0, 0, dc, ab);
    checks++; if (tbl_a[0] !== r) $display("FAIL dly_s0_tbl got %h want %h", tbl_a[0], r); else passed++;
    checks++; if (pass_a[0] !== (r == 8'hE8) || ev_a[0] !== (r != 8'hE8)) $display("FAIL dly_s0_verdict got pass=%b ev=%b want %b/%b", pass_a[0], ev_a[0], r == 8'hE8, r != 8'hE8); else passed++;
    checks++; if (fe_a[0] !== 3'(lowest(r ^ 8'hE8))) $display("FAIL dly_s0_first_err got %0d want %0d", fe_a[0], lowest(r ^ 8'hE8)); else passed++;
    dly = 1'b0;
  endtask

  task automatic test_random();
    int dc, ab, sel;
    logic [7:0] r, e;
    for (int it = 0; it < 8; it++) begin
      mode    = 3;
      rnd_tbl = 8'($urandom);
      dly     = 1'($urandom);
      sel     = $urandom_range(0, 2);
      r       = ref_tbl(sel, dly ? 2 : 0);
      e       = ($urandom_range(0, 1) == 1) ? r : 8'($urandom);
      exp_tbl = e;
      do_sweep(sel, 0, dc, ab);
      checks++; if (dc !== 8 * (sel + 1) || ab !== 0) $display("FAIL rnd%0d_timing got done=%0d bad=%0d want %0d/0", it, dc, ab, 8 * (sel + 1)); else passed++;
      checks++;
      if (tbl_a[sel] !== r || pass_a[sel] !== (r == e) || ev_a[sel] !== (r != e) || fe_a[sel] !== 3'(lowest(r ^ e)))
        $display("FAIL rnd%0d_result got tbl=%h pass=%b ev=%b fe=%0d want %h/%b/%b/%0d",
                 it, tbl_a[sel], pass_a[sel], ev_a[sel], fe_a[sel], r, r == e, r != e, lowest(r ^ e));
      else passed++;
    end
    dly = 1'b0;
  endtask

  task automatic test_start_ignored();
    int dc, ab;
    mode = 0; dly = 1'b0; exp_tbl = 8'hE8;
    do_sweep(1, 5, dc, ab);
    checks++; if (dc !== 16 || ab !== 0) $display("FAIL start_in_run got done=%0d bad=%0d want 16/0", dc, ab); else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int nd;
    mode = 3; dly = 1'b0; rnd_tbl = 8'($urandom) | 8'h07; exp_tbl = 8'($urandom);
    r = ref_tbl(1, 0) & 8'h07;
    wait_all_idle();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy_a[1] !== 1'b0 || abc_a[1] !== 3'd0) $display("FAIL abort_idle got busy=%b abc=%0d want 0/0", busy_a[1], abc_a[1]); else passed++;
    checks++; if (tbl_a[1] !== r || pass_a[1] !== 1'b0) $display("FAIL abort_partial got tbl=%h pass=%b want %h/0", tbl_a[1], pass_a[1], r); else passed++;
    nd = 0;
    for (int t = 0; t < 20; t++) begin
      if (done_a[1]) nd++;
      @(posedge clk); #1;
    end
    checks++; if (nd !== 0) $display("FAIL abort_no_done got %0d done cycles want 0", nd); else passed++;
  endtask

  task automatic test_back_to_back();
    int dc, ab, dc2;
    mode = 0; dly = 1'b0; exp_tbl = 8'hE8;
    do_sweep(1, 0, dc, ab);
    exp_tbl = 8'h17;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_tbl = 8'hE8;
    checks++; if (busy_a[1] !== 1'b1 || tbl_a[1] !== 8'h00 || pass_a[1] !== 1'b0) $display("FAIL b2b_restart got busy=%b tbl=%h pass=%b want 1/00/0", busy_a[1], tbl_a[1], pass_a[1]); else passed++;
    dc2 = -1;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk); #1;
      if (done_a[1]) begin dc2 = t; break; end
    end
    checks++; if (dc2 !== 16) $display("FAIL b2b_done_cycle got %0d want 16", dc2); else passed++;
    // Expected latched as 8'h17 on the restart edge, so majority must mismatch at bit 0.
    checks++; if (tbl_a[1] !== 8'hE8 || pass_a[1] !== 1'b0 || fe_a[1] !== 3'(lowest(8'hE8 ^ 8'h17))) $display("FAIL b2b_result got tbl=%h pass=%b fe=%0d want e8/0/%0d", tbl_a[1], pass_a[1], fe_a[1], lowest(8'hE8 ^ 8'h17)); else passed++;
  endtask

  task automatic test_reset_mid();
    int dc, ab;
    mode = 0; dly = 1'b0; exp_tbl = 8'hE8;
    wait_all_idle();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({abc_a[1], busy_a[1], done_a[1], tbl_a[1], pass_a[1], ev_a[1], fe_a[1]} !== 18'd0)
      $display("FAIL midreset_outputs got abc=%0d busy=%b tbl=%h pass=%b want all 0", abc_a[1], busy_a[1], tbl_a[1], pass_a[1]);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(1, 0, dc, ab);
    checks++; if (dc !== 16 || tbl_a[1] !== 8'hE8 || pass_a[1] !== 1'b1) $display("FAIL midreset_resweep got done=%0d tbl=%h pass=%b want 16/e8/1", dc, tbl_a[1], pass_a[1]); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_majority();
    test_parity();
    test_stuck();
    test_delayed();
    test_random();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
